// File: rtl/tag_rx_pkg.sv
// tag_rx_pkg: shared widths, tag layout and priority-to-queue mapping for tag_rx_router
package tag_rx_pkg;
  localparam int ADDR_W_D = 11;
  localparam int LEN_W_D = 4;
  localparam int SRC_W_D = 4;
  localparam int PRI_W_D = 3;
  localparam int PLD_W = ADDR_W_D + LEN_W_D + SRC_W_D;
  localparam int TAG_W = PRI_W_D + PLD_W;
  typedef struct packed {
    logic [PRI_W_D-1:0] pri;
    logic [ADDR_W_D-1:0] addr;
    logic [LEN_W_D-1:0] len;
    logic [SRC_W_D-1:0] src;
  } tag_t;
  function automatic int pri2q(input int pri, input int pri_w, input int qnum);
    return pri >> (pri_w - $clog2(qnum));
  endfunction
endpackage

// File: rtl/tag_fifo.sv
// tag_fifo: single-clock FIFO with registered storage driving the head entry; pushes are refused when full
module tag_fifo #(
  parameter int W = 19,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_pld,
  input  logic          i_pop,
  output logic          o_vld,
  output logic [W-1:0]  o_pld,
  output logic [CW-1:0] o_cnt
);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic w_push, w_pop;
  assign o_vld = r_cnt != '0;
  assign w_push = i_push & (r_cnt != CW'(DEPTH));
  assign w_pop = i_pop & o_vld;
  assign o_pld = r_mem[r_rp];
  assign o_cnt = r_cnt;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_pld;
        r_wp <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
endmodule

// File: rtl/tag_rx_router.sv
// tag_rx_router: routes priority tags into per-queue FIFOs, dropping or stalling when the target is full
// TAG_RX_STAT_EN adds a saturating drop counter and live per-queue level outputs
module tag_rx_router
  import tag_rx_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_D,
  parameter int LEN_W = LEN_W_D,
  parameter int SRC_W = SRC_W_D,
  parameter int PRI_W = PRI_W_D,
  parameter int QNUM = 8,
  parameter int DEPTH = 4,
  parameter int DROP_ON_FULL = 1,
  localparam int PW = ADDR_W + LEN_W + SRC_W,
  localparam int TW = PRI_W + PW,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic               iClk,
  input  logic               iRst_n,
  input  logic               iTagVld,
  output logic               oTagRdy,
  input  logic [TW-1:0]      iTagPld,
  output logic [QNUM-1:0]    oQueueVld,
  input  logic [QNUM-1:0]    iQueueRdy,
  output logic [QNUM*PW-1:0] oQueuePld,
  output logic               oDropVld,
  input  logic               iDropRdy,
  output logic [PW-1:0]      oDropPld
`ifdef TAG_RX_STAT_EN
  ,
  output logic [15:0]        oDropCnt,
  output logic [QNUM*CW-1:0] oQueueLvl
`endif
);
  localparam int QW = $clog2(QNUM);
  logic [PRI_W-1:0] w_pri;
  logic [QW-1:0] w_q;
  logic [QNUM-1:0] w_full;
  logic w_full_q, w_drop_free, w_acc, w_drop_ld;
  logic r_drop_vld;
  logic [PW-1:0] r_drop_pld;
  assign w_pri = iTagPld[TW-1 -: PRI_W];
  assign w_q = QW'(pri2q(int'(w_pri), PRI_W, QNUM));
  assign w_full_q = w_full[w_q];
  assign w_drop_free = !r_drop_vld | iDropRdy;
  // ready is held low during reset so nothing is accepted into cleared state
  assign oTagRdy = iRst_n & (!w_full_q | ((DROP_ON_FULL != 0) & w_drop_free));
  assign w_acc = iTagVld & oTagRdy;
  assign w_drop_ld = w_acc & w_full_q;
  assign oDropVld = r_drop_vld;
  assign oDropPld = r_drop_pld;
  genvar g;
  generate
    for (g = 0; g < QNUM; g++) begin : g_q
      logic [CW-1:0] w_cnt;
      tag_fifo #(.W(PW), .DEPTH(DEPTH)) u_fifo (
        .i_clk(iClk),
        .i_rst_n(iRst_n),
        .i_push(w_acc & (w_q == QW'(g))),
        .i_pld(iTagPld[PW-1:0]),
        .i_pop(iQueueRdy[g]),
        .o_vld(oQueueVld[g]),
        .o_pld(oQueuePld[g*PW +: PW]),
        .o_cnt(w_cnt)
      );
      assign w_full[g] = w_cnt == CW'(DEPTH);
`ifdef TAG_RX_STAT_EN
      assign oQueueLvl[g*CW +: CW] = w_cnt;
`endif
    end
  endgenerate
  always_ff @(posedge iClk or negedge iRst_n)
    if (!iRst_n) begin
      r_drop_vld <= 1'b0;
      r_drop_pld <= '0;
    end else if (w_drop_ld) begin
      r_drop_vld <= 1'b1;
      r_drop_pld <= iTagPld[PW-1:0];
    end else if (iDropRdy) r_drop_vld <= 1'b0;
`ifdef TAG_RX_STAT_EN
  logic [15:0] r_drop_cnt;
  always_ff @(posedge iClk or negedge iRst_n)
    if (!iRst_n) r_drop_cnt <= '0;
    else if (w_drop_ld && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
  assign oDropCnt = r_drop_cnt;
`endif
endmodule

// File: tb/tb_tag_rx_router.sv
// tb_tag_rx_router: directed and randomized checks of tag_rx_router in drop mode and stall mode
`timescale 1ns/1ps
module tb_tag_rx_router;
  import tag_rx_pkg::*;
  localparam int Q = 8, D = 4, PW = PLD_W, TW = TAG_W, CW = 3;
  logic clk = 1'b0, rst_n = 1'b1;
  logic tv[2], tr[2], dv[2], dr[2];
  logic [TW-1:0] tp[2];
  logic [Q-1:0] qv[2], qr[2];
  logic [Q*PW-1:0] qp[2];
  logic [PW-1:0] dp[2];
`ifdef TAG_RX_STAT_EN
  logic [15:0] dcnt[2];
  logic [Q*CW-1:0] lvl[2];
`endif
  int checks = 0, failures = 0;
  logic [PW-1:0] mq[16][$];
  logic mdv[2];
  logic [PW-1:0] mdp[2];
  always #5 clk = ~clk;
  for (genvar k = 0; k < 2; k++) begin : g_dut
    tag_rx_router #(.DROP_ON_FULL(k)) dut (
      .iClk(clk), .iRst_n(rst_n), .iTagVld(tv[k]), .oTagRdy(tr[k]), .iTagPld(tp[k]),
      .oQueueVld(qv[k]), .iQueueRdy(qr[k]), .oQueuePld(qp[k]),
      .oDropVld(dv[k]), .iDropRdy(dr[k]), .oDropPld(dp[k])
`ifdef TAG_RX_STAT_EN
      , .oDropCnt(dcnt[k]), .oQueueLvl(lvl[k])
`endif
    );
  end
  function automatic logic [TW-1:0] mk(input int pri, input int addr, input int src);
    tag_t t;
    t.pri = 3'(pri);
    t.addr = 11'(addr);
    t.len = 4'(pri + 1);
    t.src = 4'(src);
    return t;
  endfunction
  function automatic logic [PW-1:0] head(input int m, input int q);
    return qp[m][q*PW +: PW];
  endfunction
  function automatic int haddr(input int m, input int q);
    return int'(head(m, q) >> 8);
  endfunction
  function automatic int daddr(input int m);
    return int'(dp[m] >> 8);
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    for (int m = 0; m < 2; m++) begin
      tv[m] = 1'b0; tp[m] = '0; qr[m] = '0; dr[m] = 1'b1;
    end
  endtask
  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) mq[i].delete();
    mdv[0] = 1'b0; mdv[1] = 1'b0;
  endtask
  task automatic fill(input int m, input int pri, input int n, input int base);
    for (int i = 0; i < n; i++) begin
      tp[m] = mk(pri, base + i, pri); tv[m] = 1'b1;
      tick();
    end
    tv[m] = 1'b0;
  endtask
  task automatic test_reset();
    idle();
    #1 rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      checks++; if (tr[m] !== 1'b0) begin failures++; $display("FAIL reset_rdy m=%0d got=%b exp=0", m, tr[m]); end
      checks++; if (qv[m] !== '0) begin failures++; $display("FAIL reset_qvld m=%0d got=%h exp=0", m, qv[m]); end
      checks++; if (dv[m] !== 1'b0) begin failures++; $display("FAIL reset_dvld m=%0d got=%b exp=0", m, dv[m]); end
      checks++; if (qp[m] !== '0 || dp[m] !== '0) begin failures++; $display("FAIL reset_pld m=%0d got=%h/%h exp=0", m, qp[m], dp[m]); end
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask
  task automatic test_per_queue(input int m);
    do_reset();
    qr[m] = '1;
    for (int p = 0; p < 8; p++) begin
      tp[m] = mk(p, 16 * p, p); tv[m] = 1'b1;
      #1;
      checks++; if (tr[m] !== 1'b1) begin failures++; $display("FAIL pq_rdy m=%0d p=%0d got=%b exp=1", m, p, tr[m]); end
      tick();
      checks++; if (qv[m] !== 8'(1 << p)) begin failures++; $display("FAIL pq_vld m=%0d p=%0d got=%h exp=%h", m, p, qv[m], 8'(1 << p)); end
      checks++; if (haddr(m, p) != 16 * p || head(m, p)[3:0] !== 4'(p)) begin failures++; $display("FAIL pq_pld m=%0d p=%0d got=%h exp_addr=%h", m, p, head(m, p), 16 * p); end
      checks++; if (dv[m] !== 1'b0) begin failures++; $display("FAIL pq_drop m=%0d got=%b exp=0", m, dv[m]); end
    end
    tv[m] = 1'b0;
    tick();
    checks++; if (qv[m] !== '0) begin failures++; $display("FAIL pq_empty m=%0d got=%h exp=0", m, qv[m]); end
  endtask
  task automatic test_full(input int m);
    do_reset();
    fill(m, 2, 4, 1);
    tp[m] = mk(2, 5, 2); tv[m] = 1'b1;
    #1;
    if (m == 1) begin
      checks++; if (tr[m] !== 1'b1) begin failures++; $display("FAIL fd_rdy got=%b exp=1", tr[m]); end
      tick();
      tv[m] = 1'b0;
      checks++; if (dv[m] !== 1'b1 || daddr(m) != 5) begin failures++; $display("FAIL fd_drop vld=%b addr=%0d exp=1/5", dv[m], daddr(m)); end
      qr[m] = 8'h04;
      for (int a = 1; a <= 4; a++) begin
        checks++; if (qv[m][2] !== 1'b1 || haddr(m, 2) != a) begin failures++; $display("FAIL fd_order vld=%b addr=%0d exp=%0d", qv[m][2], haddr(m, 2), a); end
        tick();
        if (a == 1) begin
          checks++; if (dv[m] !== 1'b0) begin failures++; $display("FAIL fd_dclr got=%b exp=0", dv[m]); end
        end
      end
    end else begin
      checks++; if (tr[m] !== 1'b0) begin failures++; $display("FAIL st_rdy0 got=%b exp=0", tr[m]); end
      tick();
      qr[m] = 8'h04;
      #1;
      checks++; if (tr[m] !== 1'b0 || dv[m] !== 1'b0) begin failures++; $display("FAIL st_poprdy rdy=%b dvld=%b exp=0/0", tr[m], dv[m]); end
      tick();
      qr[m] = '0;
      checks++; if (tr[m] !== 1'b1 || haddr(m, 2) != 2) begin failures++; $display("FAIL st_after rdy=%b addr=%0d exp=1/2", tr[m], haddr(m, 2)); end
      tick();
      tv[m] = 1'b0;
      qr[m] = 8'h04;
      for (int a = 2; a <= 5; a++) begin
        checks++; if (qv[m][2] !== 1'b1 || haddr(m, 2) != a) begin failures++; $display("FAIL st_order vld=%b addr=%0d exp=%0d", qv[m][2], haddr(m, 2), a); end
        tick();
      end
      checks++; if (dv[m] !== 1'b0) begin failures++; $display("FAIL st_drop got=%b exp=0", dv[m]); end
    end
    checks++; if (qv[m][2] !== 1'b0) begin failures++; $display("FAIL full_drain m=%0d got=%b exp=0", m, qv[m][2]); end
  endtask
  task automatic test_pop_full();
    do_reset();
    fill(1, 5, 4, 1);
    qr[1] = 8'h20;
    tp[1] = mk(5, 9, 5); tv[1] = 1'b1;
    #1;
    checks++; if (tr[1] !== 1'b1) begin failures++; $display("FAIL pf_rdy got=%b exp=1", tr[1]); end
    tick();
    tv[1] = 1'b0;
    checks++; if (dv[1] !== 1'b1 || daddr(1) != 9) begin failures++; $display("FAIL pf_drop vld=%b addr=%0d exp=1/9", dv[1], daddr(1)); end
`ifdef TAG_RX_STAT_EN
    checks++; if (lvl[1][5*CW +: CW] !== 3'd3) begin failures++; $display("FAIL pf_lvl got=%0d exp=3", lvl[1][5*CW +: CW]); end
`endif
    for (int a = 2; a <= 4; a++) begin
      checks++; if (qv[1][5] !== 1'b1 || haddr(1, 5) != a) begin failures++; $display("FAIL pf_order vld=%b addr=%0d exp=%0d", qv[1][5], haddr(1, 5), a); end
      tick();
    end
    checks++; if (qv[1][5] !== 1'b0) begin failures++; $display("FAIL pf_cnt got=%b exp=0", qv[1][5]); end
  endtask
  task automatic test_drop_bp();
    do_reset();
    dr[1] = 1'b0;
    fill(1, 3, 4, 1);
    tp[1] = mk(3, 10, 3); tv[1] = 1'b1;
    #1;
    checks++; if (tr[1] !== 1'b1) begin failures++; $display("FAIL bp_rdy1 got=%b exp=1", tr[1]); end
    tick();
    checks++; if (dv[1] !== 1'b1 || daddr(1) != 10) begin failures++; $display("FAIL bp_load vld=%b addr=%0d exp=1/10", dv[1], daddr(1)); end
    tp[1] = mk(3, 11, 3);
    #1;
    checks++; if (tr[1] !== 1'b0) begin failures++; $display("FAIL bp_rdy0 got=%b exp=0", tr[1]); end
    tp[1] = mk(0, 12, 0);
    #1;
    checks++; if (tr[1] !== 1'b1) begin failures++; $display("FAIL bp_otherq got=%b exp=1", tr[1]); end
    tp[1] = mk(3, 11, 3);
    tick();
    checks++; if (dv[1] !== 1'b1 || daddr(1) != 10 || qv[1] !== 8'h08) begin failures++; $display("FAIL bp_hold vld=%b addr=%0d qv=%h exp=1/10/08", dv[1], daddr(1), qv[1]); end
    dr[1] = 1'b1;
    #1;
    checks++; if (tr[1] !== 1'b1) begin failures++; $display("FAIL bp_rdy2 got=%b exp=1", tr[1]); end
    tick();
    tv[1] = 1'b0;
    checks++; if (dv[1] !== 1'b1 || daddr(1) != 11) begin failures++; $display("FAIL bp_replace vld=%b addr=%0d exp=1/11", dv[1], daddr(1)); end
    tick();
    checks++; if (dv[1] !== 1'b0) begin failures++; $display("FAIL bp_clear got=%b exp=0", dv[1]); end
`ifdef TAG_RX_STAT_EN
    checks++; if (dcnt[1] !== 16'd2) begin failures++; $display("FAIL bp_dcnt got=%0d exp=2", dcnt[1]); end
`endif
  endtask
  task automatic test_reset_mid();
    do_reset();
    fill(1, 0, 3, 1);
    fill(1, 7, 3, 1);
    fill(1, 4, 5, 1);
    checks++; if (qv[1] !== 8'h91 || dv[1] !== 1'b1) begin failures++; $display("FAIL rm_pre qv=%h dv=%b exp=91/1", qv[1], dv[1]); end
    rst_n = 1'b0;
    #1;
    checks++; if (qv[1] !== '0 || dv[1] !== 1'b0 || tr[1] !== 1'b0) begin failures++; $display("FAIL rm_async qv=%h dv=%b rdy=%b exp=0/0/0", qv[1], dv[1], tr[1]); end
`ifdef TAG_RX_STAT_EN
    checks++; if (dcnt[1] !== 16'd0) begin failures++; $display("FAIL rm_dcnt got=%0d exp=0", dcnt[1]); end
`endif
    tick();
    rst_n = 1'b1;
    tick();
    tp[1] = mk(7, 'h77, 7); tv[1] = 1'b1;
    tick();
    tv[1] = 1'b0;
    checks++; if (qv[1] !== 8'h80 || haddr(1, 7) != 'h77) begin failures++; $display("FAIL rm_new qv=%h addr=%h exp=80/77", qv[1], haddr(1, 7)); end
    qr[1] = 8'h80;
    tick();
    checks++; if (qv[1] !== '0) begin failures++; $display("FAIL rm_only got=%h exp=0", qv[1]); end
  endtask
  task automatic test_random();
    int q, acc;
    logic full, er;
    logic [Q-1:0] ev;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int m = 0; m < 2; m++) begin
        tv[m] = $urandom_range(0, 3) != 0;
        tp[m] = mk($urandom_range(0, 7), $urandom_range(0, 2047), $urandom_range(0, 15));
        qr[m] = 8'($urandom) & 8'($urandom);
        dr[m] = $urandom_range(0, 1) != 0;
      end
      #1;
      for (int m = 0; m < 2; m++) begin
        q = int'(tp[m][TW-1 -: 3]);
        full = mq[m*8+q].size() == D;
        er = !full || (m == 1 && (!mdv[m] || dr[m]));
        checks++; if (tr[m] !== er) begin failures++; $display("FAIL rnd_rdy m=%0d c=%0d got=%b exp=%b", m, c, tr[m], er); end
        for (int i = 0; i < Q; i++) ev[i] = mq[m*8+i].size() != 0;
        checks++; if (qv[m] !== ev) begin failures++; $display("FAIL rnd_qvld m=%0d c=%0d got=%h exp=%h", m, c, qv[m], ev); end
        for (int i = 0; i < Q; i++)
          if (ev[i]) begin
            checks++; if (head(m, i) !== mq[m*8+i][0]) begin failures++; $display("FAIL rnd_head m=%0d q=%0d got=%h exp=%h", m, i, head(m, i), mq[m*8+i][0]); end
          end
        checks++; if (dv[m] !== mdv[m] || (mdv[m] && dp[m] !== mdp[m])) begin failures++; $display("FAIL rnd_drop m=%0d c=%0d got=%b/%h exp=%b/%h", m, c, dv[m], dp[m], mdv[m], mdp[m]); end
        acc = int'(tv[m] && er);
        for (int i = 0; i < Q; i++)
          if (ev[i] && qr[m][i]) void'(mq[m*8+i].pop_front());
        if (acc != 0 && !full) mq[m*8+q].push_back(tp[m][PW-1:0]);
        if (acc != 0 && full) begin
          mdv[m] = 1'b1; mdp[m] = tp[m][PW-1:0];
        end else if (dr[m]) mdv[m] = 1'b0;
      end
      tick();
    end
    idle();
  endtask
  initial begin
    test_reset();
    test_per_queue(0);
    test_per_queue(1);
    test_full(1);
    test_full(0);
    test_pop_full();
    test_drop_bp();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tag_rx_router.md
Name: tag_rx_router

Overview:
- Parametrised successor to the fixed 8-queue tag receiver.
- Accepts one packet tag per cycle: {priority, address+length message, source port}.
- Maps priority to one of QNUM per-priority queues, each buffered in a DEPTH-entry FIFO.
- Depending on DROP_ON_FULL, either back-pressures the source or diverts to a drop channel when the target queue is full. Sits between the switch input tag bus and the per-priority read schedulers.

Parameters:
- ADDR_W, 11, packet head-address width (`ADDR_LENTH).
- LEN_W, 4, packet length field width.
- SRC_W, 4, source port field width.
- PRI_W, 3, priority field width.
- QNUM, 8, number of priority queues, power of two, 2..2**PRI_W.
- DEPTH, 4, entries per queue FIFO, power of two, >=2.
- DROP_ON_FULL, 1, 1 = divert to drop channel when target full; 0 = stall input.

Ports:
- iClk  in  1  clock
- iRst_n  in  1  asynchronous active-low reset
- iTagVld  in  1  input tag valid
- oTagRdy  out  1  input tag ready
- iTagPld  in  PRI_W+ADDR_W+LEN_W+SRC_W  {pri, addr, len, src}, pri at MSBs
- oQueueVld  out  QNUM  per-queue head valid
- iQueueRdy  in  QNUM  per-queue consumer ready
- oQueuePld  out  QNUM*(ADDR_W+LEN_W+SRC_W)  per-queue head {addr, len, src}; queue q at slice q
- oDropVld  out  1  drop channel valid
- iDropRdy  in  1  drop channel ready
- oDropPld  out  ADDR_W+LEN_W+SRC_W  dropped {addr, len, src}

Behaviour:
- Reset: async active-low on iRst_n; all FIFOs empty, pointers/counts 0. oQueueVld=0, oDropVld=0, payloads 0, oTagRdy=0 while reset is asserted.
- Queue index: q = pri >> (PRI_W - log2(QNUM)), i.e. the top log2(QNUM) bits of pri. With QNUM=8, PRI_W=3, q = pri.
- Full/empty: full(q) = count(q)==DEPTH. A push is refused when full, even if the same cycle pops; no bypass.
- Ready:
  - DROP_ON_FULL=0: oTagRdy = !full(q).
  - DROP_ON_FULL=1: oTagRdy = !full(q) | dropFree, where dropFree = !oDropVld | iDropRdy.
  - Combinational from iTagPld pri; no dependency on iTagVld.
- Transfer: on iTagVld & oTagRdy,
  - if !full(q), push into FIFO q;
  - else (DROP_ON_FULL=1 only) load the drop register.
- Latency: tag accepted at edge N is visible on oQueueVld[q] / oDropVld after edge N. No combinational input-to-output path.
- Queue pop: on oQueueVld[q] & iQueueRdy[q], head advances. oQueueVld[q] = count(q)!=0. Head payload is stable while valid and not popped.
- Simultaneous events:
  - Push and pop on the same non-full queue: count unchanged.
  - Pops on different queues are independent; up to QNUM pops plus one push per cycle.
- Pointers: log2(DEPTH) bits, natural wrap. count is log2(DEPTH)+1 bits.
- Drop register:
  - 1-entry slice. Set on a drop load; cleared on iDropRdy without a new load.
  - Load and pop in the same cycle replaces the contents, keeping it valid.
- Ordering: tags to the same queue leave in arrival order. No ordering between queues.
- Reset mid-operation: all queued and dropped tags are discarded, with no partial output.

Optional Feature:
- Macro: TAG_RX_STAT_EN.
- Defined:
  - Extra output oDropCnt (16 bits): counts accepted-into-drop events, saturating at 0xFFFF, reset 0.
  - Extra output oQueueLvl (QNUM*(log2(DEPTH)+1) bits): live per-queue counts.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package tag_rx_pkg holds:
  - width localparams: PLD_W = ADDR_W+LEN_W+SRC_W, TAG_W = PRI_W+PLD_W;
  - typedef packed struct tag_t {pri, addr, len, src};
  - function pri2q().
- Sub-module tag_fifo: single-clock, registered-output FIFO (PLD_W, DEPTH). Instantiated QNUM times by generate.

Test Plan:
- Eight tags, pri 0..7, src = pri, addr = 0x10*pri, all iQueueRdy=1 → each appears on oQueueVld[pri] exactly one cycle after acceptance with matching src/addr, and oDropVld stays 0.
- iQueueRdy[2]=0, five tags pri 2, addr 1..5, DROP_ON_FULL=1 → queue 2 holds addr 1..4. Fifth tag appears on oDropVld with addr 5. After iQueueRdy[2]=1, queue 2 drains 1,2,3,4 in order.
- Same stimulus with DROP_ON_FULL=0 → oTagRdy=0 on the fifth tag until the first pop of queue 2, then addr 5 is accepted the next cycle. oDropVld is never 1.
- Queue 5 holding 4 entries with iQueueRdy[5]=1 and a new pri-5 tag presented → no push that cycle (drop or stall per DROP_ON_FULL); count becomes 3.
- iDropRdy=0 and the drop register full, with a full target queue and DROP_ON_FULL=1 → oTagRdy=0. After iDropRdy=1, the held drop pops and the new drop loads in the same cycle.
- iRst_n pulled low with queues 0 and 7 holding 3 entries each → oQueueVld=0 and oDropVld=0 immediately. After release, the first new pri-7 tag is the only output on queue 7. With TAG_RX_STAT_EN, oDropCnt=0.
